alu_result_serializer: RTL and testbench
========================================

# alu_result_serializer

Downstream stage of the arithmetic unit: captures every valid arithmetic result (and its carry bit) into a small FIFO and streams each result out as a byte-wide framed message over a valid/ready handshake. It decouples the arithmetic unit, which can produce one result per cycle while its enable is held, from a slower byte-oriented consumer such as a UART transmitter. Results that arrive while the FIFO is full are dropped and flagged.

## Interface
- OUT_WD, 32, result width; multiple of 8, ≥ 16
- FIFO_DEPTH, 4, result entries buffered; power of 2, ≥ 2
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- RES_IN  in  OUT_WD  signed result from the arithmetic unit
- RES_VALID  in  1  result qualifier; driven by the arithmetic unit's flag
- CARRY_IN  in  1  carry bit accompanying RES_IN
- CLR_OVF  in  1  synchronous clear of OVERFLOW
- BYTE_OUT  out  8  current output byte
- BYTE_VALID  out  1  BYTE_OUT holds a valid byte
- BYTE_READY  in  1  consumer accepts the byte
- FIFO_FULL  out  1  FIFO_DEPTH entries stored
- BUSY  out  1  frame in progress or FIFO not empty
- OVERFLOW  out  1  sticky: at least one result was dropped

## Operation
- Frame is 1 + NB bytes, where NB = OUT_WD/8:
  - header 8'hA0 | {7'b0, carry};
  - then the result, MSB byte first.
- FIFO entry: {CARRY_IN, RES_IN}, OUT_WD+1 bits.
- Push:
  - every rising edge with RES_VALID=1 is one result, so a held flag pushes one entry per cycle;
  - the push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle;
  - otherwise the result is dropped and OVERFLOW is set.
- OVERFLOW:
  - cleared by CLR_OVF or reset;
  - a drop and CLR_OVF in the same cycle leave OVERFLOW set.
- Transfer: a byte is transferred on a rising edge with BYTE_VALID=1 and BYTE_READY=1.
- FSM states:
  - IDLE: BYTE_VALID=0. If the FIFO is not empty, pop into the frame register, drive the header and go to HDR.
  - HDR: BYTE_OUT=header. On transfer, go to DATA with byte_idx=0.
  - DATA: BYTE_OUT = result byte NB-1-byte_idx. On transfer:
    - if byte_idx < NB-1, increment byte_idx;
    - else, if the FIFO is not empty, pop and go to HDR (back-to-back frames, no gap);
    - else go to IDLE.
- BYTE_OUT and BYTE_VALID stay stable while BYTE_VALID=1 and BYTE_READY=0; the output is never withdrawn.
- BYTE_READY is ignored when BYTE_VALID=0.
- BUSY = (state != IDLE) | !fifo_empty.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; the count is one bit wider.

## Timing
- Reset (asynchronous, RST=0):
  - outputs: BYTE_OUT=0, BYTE_VALID=0, FIFO_FULL=0, BUSY=0, OVERFLOW=0;
  - state: FSM to IDLE, FIFO emptied.
- Reset mid-frame aborts the frame; buffered entries are lost and no partial frame resumes.
- Latency:
  - RES_VALID sampled at edge k (FIFO was empty, FSM in IDLE) → BYTE_VALID=1 with the header after edge k+1;
  - BUSY=1 after edge k.
- With BYTE_READY held at 1, one frame takes exactly NB+1 cycles. Consecutive buffered frames stream with no idle cycle.
- FIFO_FULL is registered and updates on the edge that changes the count.

## Structure
- Shared package alu_pkg:
  - FSM state enum {IDLE, HDR, DATA};
  - header constant 8'hA0;
  - helper for NB = OUT_WD/8.
- Sub-module alu_res_fifo:
  - parameterised width and depth;
  - ports: push, pop, wdata, rdata, full, empty;
  - rdata is combinational from the read pointer;
  - push is accepted when full only if a pop occurs in the same cycle.
- The top level holds the FSM, frame register, byte index, and OVERFLOW logic.

## Test plan
- Single frame: RES_IN=32'h1234_5678, CARRY_IN=1 for 1 cycle, BYTE_READY=1 → bytes A1,12,34,56,78 on 5 consecutive cycles; header appears 2 edges after the sample; BUSY then falls.
- Backpressure: same result with BYTE_READY toggling 0/1 each cycle → the same 5 bytes in order; BYTE_OUT is stable during every stall.
- Burst and overflow: RES_VALID held 7 cycles with values 1..7, BYTE_READY=0:
  - first value popped, next 4 buffered, FIFO_FULL=1;
  - values 6 and 7 dropped, OVERFLOW=1;
  - after releasing BYTE_READY, frames 1–5 stream back-to-back with no gap.
- Full with simultaneous push/pop: FIFO full, push coincides with the final data byte transfer → push accepted, no OVERFLOW, order preserved.
- CLR_OVF: pulse with no drop → OVERFLOW=0; pulse coinciding with a drop → OVERFLOW stays 1.
- Reset mid-frame: assert RST after the second data byte → all outputs 0 immediately; after release, no residual bytes, and a new result produces a fresh complete frame.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result serializer.
// Frame layout: one header byte followed by the result, MSB byte first.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_e;

  localparam logic [7:0] HDR_BYTE = 8'hA0;

  function automatic int nb_of(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Small result FIFO with combinational read data and a registered full flag.
// A push into a full FIFO is taken only when a pop frees a slot that cycle.
module alu_res_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          full_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = full_q;
  assign rdata   = mem_q[rp_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results with carry and streams each one out as a
// byte-wide framed message over a valid/ready handshake.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int OUT_WD     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [OUT_WD-1:0] RES_IN,
  input  logic              RES_VALID,
  input  logic              CARRY_IN,
  input  logic              CLR_OVF,
  output logic [7:0]        BYTE_OUT,
  output logic              BYTE_VALID,
  input  logic              BYTE_READY,
  output logic              FIFO_FULL,
  output logic              BUSY,
  output logic              OVERFLOW
);

  localparam int NB = nb_of(OUT_WD);
  localparam int IW = $clog2(NB);

  state_e            state_q;
  state_e            state_d;
  logic [OUT_WD:0]   frame_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     idx_d;
  logic [IW-1:0]     sel;
  logic [OUT_WD-1:0] shifted;
  logic              ovf_q;
  logic              ovf_d;
  logic [OUT_WD:0]   rdata;
  logic              full;
  logic              empty;
  logic              xfer;
  logic              last;
  logic              pop;
  logic              drop;

  assign xfer = BYTE_VALID & BYTE_READY;
  assign last = (idx_q == IW'(NB-1));
  assign pop  = ((state_q == IDLE) & ~empty)
              | ((state_q == DATA) & xfer & last & ~empty);
  assign drop = RES_VALID & full & ~pop;

  alu_res_fifo #(
    .W     (OUT_WD + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (RES_VALID),
    .pop   (pop),
    .wdata ({CARRY_IN, RES_IN}),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = HDR;
      HDR:     if (xfer) state_d = DATA;
      DATA:    if (xfer && last) state_d = empty ? IDLE : HDR;
      default: state_d = IDLE;
    endcase
  end

  // Byte index counts data bytes from the MSB end of the result.
  always_comb begin
    sel        = IW'(NB-1) - idx_q;
    shifted    = frame_q[OUT_WD-1:0] >> {sel, 3'b000};
    BYTE_VALID = (state_q != IDLE);
    BYTE_OUT   = 8'h00;
    unique case (state_q)
      HDR:     BYTE_OUT = HDR_BYTE | {7'b0, frame_q[OUT_WD]};
      DATA:    BYTE_OUT = shifted[7:0];
      default: BYTE_OUT = 8'h00;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (state_q == HDR && xfer)
      idx_d = '0;
    else if (state_q == DATA && xfer && !last)
      idx_d = idx_q + 1'b1;
  end

  assign ovf_d = drop | (ovf_q & ~CLR_OVF);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (pop) frame_q <= rdata;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end

  assign FIFO_FULL = full;
  assign BUSY      = (state_q != IDLE) | ~empty;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed self-checking bench for alu_result_serializer.
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_alu_result_serializer;

  logic        CLK;
  logic        RST;
  logic [31:0] RES_IN;
  logic        RES_VALID;
  logic        CARRY_IN;
  logic        CLR_OVF;
  logic [7:0]  BYTE_OUT;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic        FIFO_FULL;
  logic        BUSY;
  logic        OVERFLOW;

  int errors = 0;
  int checks = 0;

  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int first_c;
  int last_c;

  alu_result_serializer #(
    .OUT_WD     (32),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RES_IN     (RES_IN),
    .RES_VALID  (RES_VALID),
    .CARRY_IN   (CARRY_IN),
    .CLR_OVF    (CLR_OVF),
    .BYTE_OUT   (BYTE_OUT),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_READY (BYTE_READY),
    .FIFO_FULL  (FIFO_FULL),
    .BUSY       (BUSY),
    .OVERFLOW   (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic c, input logic [31:0] v);
    exp_q.push_back(8'hA0 | {7'b0, c});
    exp_q.push_back(v[31:24]);
    exp_q.push_back(v[23:16]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endtask

  // Collect n bytes; optional ready toggling and one injected push.
  task automatic drain(input int n, input bit toggle,
                       input int inj_c, input logic [31:0] inj_v);
    logic       prev_stall;
    logic [7:0] prev_byte;
    got.delete();
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    first_c    = -1;
    last_c     = -1;
    for (int c = 0; c < 400 && got.size() < n; c++) begin
      BYTE_READY = toggle ? c[0] : 1'b1;
      RES_VALID  = (c == inj_c);
      RES_IN     = inj_v;
      CARRY_IN   = 1'b0;
      if (prev_stall)
        chk("stall_stable", {23'b0, BYTE_VALID, BYTE_OUT},
            {23'b0, 1'b1, prev_byte});
      prev_stall = BYTE_VALID & ~BYTE_READY;
      prev_byte  = BYTE_OUT;
      if (BYTE_VALID && BYTE_READY) begin
        got.push_back(BYTE_OUT);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      tick();
    end
    RES_VALID = 1'b0;
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i),
          (i < got.size()) ? {24'b0, got[i]} : 32'hxxxx_xxxx,
          {24'b0, exp_q[i]});
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 50 && BUSY; c++) tick();
    chk(tag, BUSY, 1'b0);
  endtask

  initial begin
    RST        = 1'b0;
    RES_IN     = '0;
    RES_VALID  = 1'b0;
    CARRY_IN   = 1'b0;
    CLR_OVF    = 1'b0;
    BYTE_READY = 1'b0;
    tick();
    tick();
    chk("rst_byte_out", BYTE_OUT, 8'h00);
    chk("rst_valid", BYTE_VALID, 1'b0);
    chk("rst_full", FIFO_FULL, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_ovf", OVERFLOW, 1'b0);
    RST = 1'b1;
    tick();

    // Single frame, ready held high
    RES_IN     = 32'h1234_5678;
    CARRY_IN   = 1'b1;
    RES_VALID  = 1'b1;
    BYTE_READY = 1'b1;
    tick();
    RES_VALID = 1'b0;
    CARRY_IN  = 1'b0;
    chk("lat_busy", BUSY, 1'b1);
    chk("lat_valid_early", BYTE_VALID, 1'b0);
    tick();
    chk("single_v0", BYTE_VALID, 1'b1);
    chk("single_b0", BYTE_OUT, 8'hA1);
    tick();
    chk("single_v1", BYTE_VALID, 1'b1);
    chk("single_b1", BYTE_OUT, 8'h12);
    tick();
    chk("single_b2", BYTE_OUT, 8'h34);
    tick();
    chk("single_b3", BYTE_OUT, 8'h56);
    tick();
    chk("single_v4", BYTE_VALID, 1'b1);
    chk("single_b4", BYTE_OUT, 8'h78);
    tick();
    chk("single_done_valid", BYTE_VALID, 1'b0);
    chk("single_done_busy", BUSY, 1'b0);

    // Backpressure with toggling ready
    RES_IN    = 32'h1234_5678;
    CARRY_IN  = 1'b1;
    RES_VALID = 1'b1;
    tick();
    RES_VALID = 1'b0;
    drain(5, 1'b1, -1, 32'h0);
    add_frame(1'b1, 32'h1234_5678);
    check_got("bp");
    wait_idle("bp_idle");

    // Burst of 7 with consumer stalled
    BYTE_READY = 1'b0;
    for (int v = 1; v <= 7; v++) begin
      RES_IN    = 32'(v);
      CARRY_IN  = v[0];
      RES_VALID = 1'b1;
      tick();
      if (v == 5) begin
        chk("burst_full_at5", FIFO_FULL, 1'b1);
        chk("burst_ovf_at5", OVERFLOW, 1'b0);
      end
    end
    RES_VALID = 1'b0;
    chk("burst_full", FIFO_FULL, 1'b1);
    chk("burst_ovf", OVERFLOW, 1'b1);
    chk("burst_hdr", BYTE_OUT, 8'hA1);

    // Clear with no drop in the same cycle
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    chk("clr_ovf", OVERFLOW, 1'b0);
    chk("clr_full_kept", FIFO_FULL, 1'b1);

    // Stream, pushing into the full FIFO on frame 1's last byte
    drain(30, 1'b0, 4, 32'h0000_0099);
    for (int v = 1; v <= 5; v++) add_frame(v[0], 32'(v));
    add_frame(1'b0, 32'h0000_0099);
    check_got("stream");
    chk("stream_no_gap", last_c - first_c, 29);
    chk("stream_no_ovf", OVERFLOW, 1'b0);
    wait_idle("stream_idle");
    chk("stream_full_clr", FIFO_FULL, 1'b0);

    // Clear coinciding with a drop keeps OVERFLOW set
    BYTE_READY = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      RES_IN    = 32'h10 + 32'(v);
      RES_VALID = 1'b1;
      CLR_OVF   = (v == 6);
      tick();
    end
    RES_VALID = 1'b0;
    CLR_OVF   = 1'b0;
    chk("clr_drop_ovf", OVERFLOW, 1'b1);

    // Reset after the second data byte is transferred
    BYTE_READY = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_byte", BYTE_OUT, 8'h00);
    chk("pre_rst_valid", BYTE_VALID, 1'b1);
    RST = 1'b0;
    #1;
    chk("mid_rst_byte", BYTE_OUT, 8'h00);
    chk("mid_rst_valid", BYTE_VALID, 1'b0);
    chk("mid_rst_full", FIFO_FULL, 1'b0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_ovf", OVERFLOW, 1'b0);
    tick();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_quiet", {BYTE_VALID, BUSY}, 2'b00);
    end
    RES_IN    = 32'hDEAD_BEEF;
    CARRY_IN  = 1'b0;
    RES_VALID = 1'b1;
    tick();
    RES_VALID = 1'b0;
    drain(5, 1'b0, -1, 32'h0);
    add_frame(1'b0, 32'hDEAD_BEEF);
    check_got("fresh");
    wait_idle("fresh_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
